gcd_control_path: RTL and testbench
===================================

# gcd_control_path

Iterative 16-bit greatest-common-divisor engine built from a controller FSM and a subtract/compare datapath. The two operands arrive serially on one data bus, and the block computes their GCD by repeated subtraction. It then holds the result with `done` asserted. It is a standalone compute block inside the datapath/controller examples; the controller and datapath may be separate submodules, but this spec defines their combined behaviour at the block boundary.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width.

Ports:
- `clock`  input  1  single clock, all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  level request. Sampled in IDLE; must remain high until `done` is to be released.
- `data_in`  input  WIDTH  operand bus. Carries A in the IDLE/start cycle and B in the following cycle.
- `done`  output  1  high while the result is valid (DONE state).
- `a_out`  output  WIDTH  A register contents. Equals the GCD while `done`=1.
- `lt`, `gt`, `eq`  output  1 each  combinational comparisons A<B, A>B, A==B of the current registers (status to controller, exposed for debug).

## Operation
- Registers: A, B (WIDTH bits each), state register.
- States:
  - IDLE
    - `done`=0.
    - If `start`=1 at an edge: A<=`data_in`, go to LOADB.
  - LOADB
    - B<=`data_in` unconditionally, go to CALC.
  - CALC, evaluated in priority order at each edge:
    - B==0: go to DONE (A already holds the result).
    - A==0: A<=B, go to DONE.
    - A==B: go to DONE.
    - A>B: A<=A-B, stay in CALC.
    - A<B: B<=B-A, stay in CALC.
  - DONE
    - `done`=1; A and B hold their values.
    - If `start`=0 at an edge: go to IDLE.
- Subtraction is unsigned WIDTH-bit. The guarded branch ordering means it never underflows.
- Both operands zero: result 0, `done` asserted.
- `done` is a Moore output decoded from state, so it is glitch-free.
- `a_out` is valid only while `done`=1. It may change freely during CALC.

## Timing
- Reset values: state=IDLE, A=0, B=0, `done`=0, `a_out`=0.
- Reset asserted mid-computation aborts immediately. The block returns to IDLE with no partial result held.
- Operand capture:
  - A is captured on the edge where IDLE sees `start`=1.
  - B is captured on the very next edge.
  - The source must present A then B on consecutive cycles.
- Each CALC cycle performs at most one subtraction.
  - Latency from the B-capture edge to `done` rising = (number of subtractions + 1) edges.
- `start` held high through DONE keeps the result latched indefinitely.
  - A new computation requires `start` low for at least one edge, then high again.
- `data_in` is ignored in CALC and DONE.
- Comparison outputs reflect the registers after each edge, with no extra cycle delay.

## Test plan
- Nominal case:
  - Stimulus: reset, then `start`=1 with `data_in`=143, then 78 next cycle.
  - A/B sequence: (143,78) → (65,78) → (65,13) → (52,13) → (39,13) → (26,13) → (13,13).
  - Required: `done` rises 7 edges after B capture, `a_out`=13, and both stay stable while `start`=1.
- Equal operands 40,40:
  - Required: `done` one edge after B capture, `a_out`=40.
- Coprime 17,5:
  - Required: `a_out`=1 with `done`=1.
  - A≥B ordering invariants hold every cycle, with no underflow.
- Zero operands:
  - 0,9 → `a_out`=9.
  - 9,0 → `a_out`=9.
  - 0,0 → `a_out`=0.
  - Each with `done` asserted within 2 edges of B capture.
- Reset mid-CALC during the 143/78 run:
  - Required: immediately `done`=0 and `a_out`=0, state IDLE.
  - A subsequent 48,18 run yields 6.
- Restart:
  - Stimulus: after `done`, drop `start` for one cycle, then start a new run with 100,75.
  - Required: `done` falls on the IDLE return, then the new result is 25.

Source files
------------

// File: rtl/gcd_control_path.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_control_path (with gcd_datapath, gcd_controller)
//  Purpose  : Iterative greatest-common-divisor engine. The two operands
//             arrive on one bus in consecutive cycles. Their GCD is found by
//             repeated subtraction and then held with done asserted.
//
//  Ports (gcd_control_path):
//    clock    in   1      rising-edge clock
//    reset    in   1      asynchronous, active-high; clears all state
//    start    in   1      level request; A is captured when IDLE sees it
//                         high, B on the next edge; hold high to keep the
//                         result, drop low to return to IDLE
//    data_in  in   WIDTH  operand bus (A, then B on the following cycle)
//    done     out  1      result valid (Moore, decoded from state)
//    a_out    out  WIDTH  A register; equals the GCD while done = 1
//    lt/gt/eq out  1      A<B, A>B, A==B of the current registers
//
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  gcd_datapath : A/B registers, subtractors and comparators.
// ----------------------------------------------------------------------------
module gcd_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,    // A <= data_in
    input  logic             load_b,    // B <= data_in
    input  logic             a_from_b,  // A <= B (A was zero)
    input  logic             a_sub,     // A <= A - B
    input  logic             b_sub,     // B <= B - A
    output logic [WIDTH-1:0] a_out,
    output logic             a_zero,
    output logic             b_zero,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_minus_b;
    logic [WIDTH-1:0] w_b_minus_a;

    // The controller only selects a subtraction whose minuend is the larger
    // register, so these never wrap when their result is actually used.
    assign w_a_minus_b = r_a - r_b;
    assign w_b_minus_a = r_b - r_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a <= '0;
        end else if (load_a) begin
            r_a <= data_in;
        end else if (a_from_b) begin
            r_a <= r_b;
        end else if (a_sub) begin
            r_a <= w_a_minus_b;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_b <= '0;
        end else if (load_b) begin
            r_b <= data_in;
        end else if (b_sub) begin
            r_b <= w_b_minus_a;
        end
    end

    // Status is purely combinational on the registers, so it tracks every
    // edge without an extra cycle of delay.
    assign a_out  = r_a;
    assign a_zero = (r_a == '0);
    assign b_zero = (r_b == '0);
    assign lt     = (r_a <  r_b);
    assign gt     = (r_a >  r_b);
    assign eq     = (r_a == r_b);

endmodule

// ----------------------------------------------------------------------------
//  gcd_controller : IDLE -> LOADB -> CALC (loop) -> DONE -> IDLE
// ----------------------------------------------------------------------------
module gcd_controller (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic a_zero,
    input  logic b_zero,
    input  logic gt,
    input  logic eq,
    output logic load_a,
    output logic load_b,
    output logic a_from_b,
    output logic a_sub,
    output logic b_sub,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOADB = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        load_a       = 1'b0;
        load_b       = 1'b0;
        a_from_b     = 1'b0;
        a_sub        = 1'b0;
        b_sub        = 1'b0;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    load_a       = 1'b1;
                    w_next_state = ST_LOADB;
                end
            end

            ST_LOADB: begin
                load_b       = 1'b1;
                w_next_state = ST_CALC;
            end

            ST_CALC: begin
                // Zero checks come first: with a zero operand the
                // subtraction loop would never converge.
                if (b_zero) begin
                    w_next_state = ST_DONE;
                end else if (a_zero) begin
                    a_from_b     = 1'b1;
                    w_next_state = ST_DONE;
                end else if (eq) begin
                    w_next_state = ST_DONE;
                end else if (gt) begin
                    a_sub        = 1'b1;
                end else begin
                    b_sub        = 1'b1;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
//  gcd_control_path : top level, controller plus datapath.
// ----------------------------------------------------------------------------
module gcd_control_path #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    logic w_load_a;
    logic w_load_b;
    logic w_a_from_b;
    logic w_a_sub;
    logic w_b_sub;
    logic w_a_zero;
    logic w_b_zero;

    gcd_controller u_ctrl (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a_zero   (w_a_zero),
        .b_zero   (w_b_zero),
        .gt       (gt),
        .eq       (eq),
        .load_a   (w_load_a),
        .load_b   (w_load_b),
        .a_from_b (w_a_from_b),
        .a_sub    (w_a_sub),
        .b_sub    (w_b_sub),
        .done     (done)
    );

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .load_a   (w_load_a),
        .load_b   (w_load_b),
        .a_from_b (w_a_from_b),
        .a_sub    (w_a_sub),
        .b_sub    (w_b_sub),
        .a_out    (a_out),
        .a_zero   (w_a_zero),
        .b_zero   (w_b_zero),
        .lt       (lt),
        .gt       (gt),
        .eq       (eq)
    );

endmodule
`default_nettype wire

// File: tb/tb_gcd_control_path.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_control_path
//  Purpose  : Self-checking bench for gcd_control_path. A table of operand
//             pairs with hand-computed GCDs and latencies is applied in a
//             loop; a step model of the subtraction algorithm is compared
//             against a_out, done and the flags every cycle. Hand-written
//             sequences cover reset, hold-while-start, abort and restart.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_control_path;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic         done;
    logic [W-1:0] a_out;
    logic         lt;
    logic         gt;
    logic         eq;

    int checks   = 0;
    int failures = 0;

    gcd_control_path #(
        .WIDTH (W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .a_out   (a_out),
        .lt      (lt),
        .gt      (gt),
        .eq      (eq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;    // expected GCD
        int           lat;  // edges from B capture to done rising
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string name, input logic [W-1:0] ma, input logic [W-1:0] mb);
        chk({name, "_lt"}, {31'd0, lt}, {31'd0, (ma < mb)});
        chk({name, "_gt"}, {31'd0, gt}, {31'd0, (ma > mb)});
        chk({name, "_eq"}, {31'd0, eq}, {31'd0, (ma == mb)});
    endtask

    // One full computation starting from IDLE or DONE. Leaves start high
    // with the DUT in DONE.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] g, input int exp_lat);
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        bit           mdone;
        int           lat;

        start = 1'b0;
        tick();
        chk("idle_done", {31'd0, done}, 32'd0);

        start   = 1'b1;
        data_in = a;
        tick();
        chk("capA_a_out", {16'd0, a_out}, {16'd0, a});
        chk("capA_done", {31'd0, done}, 32'd0);

        data_in = b;
        ma      = a;
        mb      = b;
        tick();
        chk_flags("capB", ma, mb);
        data_in = 16'hDEAD;  // must be ignored from here on

        mdone = 1'b0;
        lat   = 0;
        while (!mdone && lat < 100) begin
            if (mb == '0) begin
                mdone = 1'b1;
            end else if (ma == '0) begin
                ma    = mb;
                mdone = 1'b1;
            end else if (ma == mb) begin
                mdone = 1'b1;
            end else if (ma > mb) begin
                ma = ma - mb;
            end else begin
                mb = mb - ma;
            end
            tick();
            lat++;
            chk("step_done", {31'd0, done}, {31'd0, mdone});
            chk("step_a_out", {16'd0, a_out}, {16'd0, ma});
            chk_flags("step", ma, mb);
        end
        chk("latency", lat, exp_lat);
        chk("gcd", {16'd0, a_out}, {16'd0, g});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{a: 16'd143, b: 16'd78,  g: 16'd13, lat: 7};
        vecs[1] = '{a: 16'd40,  b: 16'd40,  g: 16'd40, lat: 1};
        vecs[2] = '{a: 16'd17,  b: 16'd5,   g: 16'd1,  lat: 7};
        vecs[3] = '{a: 16'd0,   b: 16'd9,   g: 16'd9,  lat: 1};
        vecs[4] = '{a: 16'd9,   b: 16'd0,   g: 16'd9,  lat: 1};
        vecs[5] = '{a: 16'd0,   b: 16'd0,   g: 16'd0,  lat: 1};
        vecs[6] = '{a: 16'd48,  b: 16'd18,  g: 16'd6,  lat: 5};
        vecs[7] = '{a: 16'd100, b: 16'd75,  g: 16'd25, lat: 4};

        // ---- reset state ----
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        tick();
        tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_a_out", {16'd0, a_out}, 32'd0);
        chk_flags("rst", 16'd0, 16'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);

        // ---- table-driven runs ----
        for (int i = 0; i < 8; i++) begin
            run(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].lat);
        end

        // ---- nominal run, result held while start stays high ----
        run(16'd143, 16'd78, 16'd13, 7);
        for (int k = 0; k < 4; k++) begin
            data_in = 16'(k * 1111 + 7);
            tick();
            chk("hold_done", {31'd0, done}, 32'd1);
            chk("hold_a_out", {16'd0, a_out}, 32'd13);
        end

        // ---- reset mid-CALC aborts immediately ----
        start = 1'b0;
        tick();
        start   = 1'b1;
        data_in = 16'd143;
        tick();
        data_in = 16'd78;
        tick();          // B captured
        tick();          // (65,78)
        tick();          // (65,13)
        chk("pre_abort_a_out", {16'd0, a_out}, 32'd65);
        chk("pre_abort_done", {31'd0, done}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_a_out", {16'd0, a_out}, 32'd0);
        chk_flags("abort", 16'd0, 16'd0);
        tick();
        chk("abort_hold_done", {31'd0, done}, 32'd0);
        chk("abort_hold_a_out", {16'd0, a_out}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("abort_idle_a_out", {16'd0, a_out}, 32'd0);
        run(16'd48, 16'd18, 16'd6, 5);

        // ---- restart: drop start one cycle, done falls, then new run ----
        start = 1'b0;
        tick();
        chk("restart_done_fall", {31'd0, done}, 32'd0);
        start   = 1'b1;
        data_in = 16'd100;
        tick();
        chk("restart_capA", {16'd0, a_out}, 32'd100);
        chk("restart_capA_done", {31'd0, done}, 32'd0);
        data_in = 16'd75;
        tick();          // B captured: (100,75)
        for (int k = 0; k < 4; k++) begin
            chk("restart_busy", {31'd0, done}, 32'd0);
            tick();      // (25,75) (25,50) (25,25) DONE
        end
        chk("restart_done", {31'd0, done}, 32'd1);
        chk("restart_gcd", {16'd0, a_out}, 32'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
